// File: rtl/wb_arbiter.sv
// Two-initiator round-robin Wishbone arbiter with a wait-state watchdog.
// Grants are held for a whole cyc tenure; hung targets are aborted with err.
module wb_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0__cyc,
    input  logic        m0__stb,
    input  logic        m0__we,
    input  logic [3:0]  m0__sel,
    input  logic [29:0] m0__adr,
    input  logic [31:0] m0__dat_w,
    output logic [31:0] m0__dat_r,
    output logic        m0__ack,
    output logic        m0__err,

    input  logic        m1__cyc,
    input  logic        m1__stb,
    input  logic        m1__we,
    input  logic [3:0]  m1__sel,
    input  logic [29:0] m1__adr,
    input  logic [31:0] m1__dat_w,
    output logic [31:0] m1__dat_r,
    output logic        m1__ack,
    output logic        m1__err,

    output logic        bus__cyc,
    output logic        bus__stb,
    output logic        bus__we,
    output logic [3:0]  bus__sel,
    output logic [29:0] bus__adr,
    output logic [31:0] bus__dat_w,
    input  logic [31:0] bus__dat_r,
    input  logic        bus__ack,

    output logic        timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own0, own1, abort;

    // Ownership is masked by reset so a target mid-access sees cyc drop.
    assign own0 = (state_q == GRANT0) & ~rst;
    assign own1 = (state_q == GRANT1) & ~rst;

    always_comb begin
        bus__cyc   = 1'b0;
        bus__stb   = 1'b0;
        bus__we    = 1'b0;
        bus__sel   = '0;
        bus__adr   = '0;
        bus__dat_w = '0;
        if (own0) begin
            bus__cyc   = m0__cyc;
            bus__stb   = m0__stb & m0__cyc;
            bus__we    = m0__we;
            bus__sel   = m0__sel;
            bus__adr   = m0__adr;
            bus__dat_w = m0__dat_w;
        end else if (own1) begin
            bus__cyc   = m1__cyc;
            bus__stb   = m1__stb & m1__cyc;
            bus__we    = m1__we;
            bus__sel   = m1__sel;
            bus__adr   = m1__adr;
            bus__dat_w = m1__dat_w;
        end
    end

    // Ack beats abort when both land in the same cycle.
    assign abort = bus__stb & ~bus__ack & (cnt_q == TMAX);

    assign m0__ack   = own0 & bus__ack & bus__stb;
    assign m1__ack   = own1 & bus__ack & bus__stb;
    assign m0__err   = own0 & abort;
    assign m1__err   = own1 & abort;
    assign timeout   = abort;
    assign m0__dat_r = bus__dat_r;
    assign m1__dat_r = bus__dat_r;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0__cyc && m1__cyc)
                    state_d = last_q ? GRANT0 : GRANT1;
                else if (m0__cyc)
                    state_d = GRANT0;
                else if (m1__cyc)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (!m0__cyc) begin
                    last_d  = 1'b0;
                    state_d = m1__cyc ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!m1__cyc) begin
                    last_d  = 1'b1;
                    state_d = m0__cyc ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!bus__stb || bus__ack || abort || (state_d != state_q))
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-initiator Wishbone arbiter with a bus watchdog, placed between the `sentinel` core's bus port (initiator 0) and a second initiator such as a debug or DMA port (initiator 1), driving one shared target bus. Grants are round-robin and held for a whole `cyc` tenure, which allows back-to-back and block transfers. A wait-state counter aborts any access the target fails to acknowledge within `TIMEOUT` cycles and returns `err` to the owner, so a hung peripheral cannot stall the system.

## Interface
- `TIMEOUT`, 15: maximum wait cycles (stb high, no ack) before abort; range 1..255.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0__cyc`, `m0__stb`, `m0__we`  in  1 each  initiator 0 cycle, strobe, write enable.
- `m0__sel`  in  4  initiator 0 byte selects.
- `m0__adr`  in  30  initiator 0 word address.
- `m0__dat_w`  in  32  initiator 0 write data.
- `m0__dat_r`  out  32  read data to initiator 0.
- `m0__ack`, `m0__err`  out  1 each  acknowledge and abort to initiator 0.
- `m1__*`: same set of ports as `m0__*`, for initiator 1.
- `bus__cyc`, `bus__stb`, `bus__we`  out  1 each  target cycle, strobe, write enable.
- `bus__sel`  out  4  target byte selects.
- `bus__adr`  out  30  target word address.
- `bus__dat_w`  out  32  target write data.
- `bus__dat_r`  in  32  target read data.
- `bus__ack`  in  1  target acknowledge.
- `timeout`  out  1  one-cycle pulse when an abort fires.

## Operation
- **State machine:** `IDLE`, `GRANT0`, `GRANT1`. A 1-bit `last` register records the most recent owner. Reset gives state `IDLE`, `last`=1, so initiator 0 wins the first tie.
- **From `IDLE`:**
  - If only one `mN__cyc` is high, go to `GRANTn`.
  - If both are high, go to the initiator that is not `last`.
  - If neither is high, stay in `IDLE`.
- **From `GRANTn`:**
  - Stay while `mn__cyc` is high.
  - When `mn__cyc` is low, set `last`=n and hand over. The next state is `GRANT(other)` if the other `cyc` is high, else `IDLE`.
  - Handover costs zero idle cycles.
- **Routing while in `GRANTn`:**
  - `bus__cyc` = `mn__cyc`.
  - `bus__stb` = `mn__stb & mn__cyc`.
  - `we`, `sel`, `adr` and `dat_w` are taken from initiator n.
  - `mn__ack` = `bus__ack & bus__stb`.
- **Routing in `IDLE`:** all `bus__*` outputs are 0.
- **Non-owner outputs:** `ack` and `err` are 0 for the initiator that does not own the bus.
- **Read data:** `bus__dat_r` is broadcast to both `mN__dat_r` unconditionally.
- **Watchdog counter:**
  - Width is `$clog2(TIMEOUT+1)` bits.
  - It increments each cycle with `bus__stb & !bus__ack`.
  - It clears to 0 on `bus__ack`, on `!bus__stb`, on any state change, and on an abort.
- **Abort:** in a cycle where the counter equals `TIMEOUT` and `bus__stb & !bus__ack`:
  - `mn__err`=1 and `timeout`=1 for that cycle.
  - The counter clears.
  - The owner is expected to drop `stb` or `cyc`. If it keeps `stb` high, counting restarts from 0.
- **Ack/abort collision:** if `bus__ack` and the abort condition fall in the same cycle, ack wins and `err` is not asserted.
- **Reset mid-transfer:** state, `last` and counter reinitialise at the edge. While `rst` is high, all outputs except `dat_r` are forced to 0 combinationally, so a target mid-access sees `cyc` drop.

## Timing
- **Reset values:** state `IDLE`, `last`=1, counter 0. All `bus__*`, `mN__ack`, `mN__err` and `timeout` are 0.
- **Grant latency:** a request seen in `IDLE` in cycle N produces `bus__cyc` in cycle N+1 (grant is registered).
- **Combinational paths, no added latency:**
  - `bus__ack` to `mN__ack`.
  - `bus__dat_r` to `mN__dat_r`.
  - Owner request signals to `bus__*`.
- **Release:** `mn__cyc` low in cycle N makes `bus__cyc` low in cycle N.
- **Handover:** the new owner drives the bus in cycle N+1.
- **Abort timing:** the earliest abort is `TIMEOUT`+1 cycles after `bus__stb` rises with no ack. The counter equals k on the (k+1)th waiting cycle.
- **No combinational path** from `bus__*` inputs to state, except through registers.

## Test plan
- **Single initiator:** `m0` issues a read to `adr`=0x10; the target acks on its 2nd stb cycle with 0xDEADBEEF. Required: `bus__cyc` rises 1 cycle after `m0__cyc`; `m0__ack` pulses once; `m0__dat_r`=0xDEADBEEF; `m1__ack`=0.
- **Simultaneous requests from reset:** both initiators request in the same cycle. Required: `m0` is granted first; when `m0__cyc` drops, `m1` drives the bus the next cycle. A repeated tie after that grants `m0` again (alternation).
- **Held grant:** `m0` keeps `cyc` high for 4 back-to-back writes while `m1` requests. Required: `m1` gets no ack and `bus__adr` never shows `m1__adr` until `m0__cyc` drops.
- **Timeout abort:** with `TIMEOUT`=3, `m1` strobes and the target never acks. Required: `m1__err` and `timeout` pulse exactly on the 4th stb cycle; `m1__ack` stays 0.
- **Ack/abort collision:** `bus__ack` arrives in the same cycle as the abort condition. Required: `ack`=1, `err`=0, `timeout`=0.
- **Reset mid-transfer:** `rst` is asserted for 1 cycle while `GRANT1` is active with stb pending. Required: all `bus__*` outputs are 0 during `rst`; after `rst`, a tie grants `m0`.
